// File: rtl/jtpopeye_obj_dma_pkg.sv
// Shared definitions for the Popeye sprite DMA: FSM encoding, bus widths and
// the object RAM window base in the main CPU map.
package jtpopeye_obj_dma_pkg;

  localparam int AW = 10;                       // object RAM offset width
  localparam int DW = 8;                        // object RAM data width
  localparam logic [15:0] OBJ_BASE = 16'h8C00;  // object RAM window in main RAM

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_DRAIN,
    ST_REL,
    ST_ABORT
  } dma_state_t;

  // Address step that parks on the final address instead of wrapping
  function automatic logic [AW-1:0] addr_step(input logic [AW-1:0] a,
                                              input logic [AW-1:0] last);
    return (a == last) ? a : a + AW'(1);
  endfunction

endpackage

// File: rtl/jtpopeye_obj_dma_pipe.sv
// Read-latency delay line: carries a valid tag and the issued address so the
// write side knows which object buffer slot the returning RAM byte belongs to.
module jtpopeye_obj_dma_pipe
  import jtpopeye_obj_dma_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_vld,
  input  logic [AW-1:0] in_addr,
  output logic          out_vld,
  output logic [AW-1:0] out_addr,
  output logic          empty
);

  logic [RD_LAT:1] vld_p;
  logic [AW-1:0]   addr_p [1:RD_LAT];

  // Valid tags shift every clk; a flush drops everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p[1] <= in_vld & ~flush;
      for (int i = 2; i <= RD_LAT; i++) begin
        vld_p[i] <= vld_p[i-1] & ~flush;
      end
    end
  end

  // Address payload follows the tags; only meaningful where the tag is set
  always_ff @(posedge clk) begin
    addr_p[1] <= in_addr;
    for (int i = 2; i <= RD_LAT; i++) begin
      addr_p[i] <= addr_p[i-1];
    end
  end

  assign out_vld  = vld_p[RD_LAT];
  assign out_addr = addr_p[RD_LAT];
  assign empty    = ~|vld_p;

endmodule

// File: rtl/jtpopeye_obj_dma.sv
// Popeye sprite DMA. On each enabled vertical blank it takes the Z80 bus,
// streams object RAM into the video object buffer and hands the bus back,
// flagging either a clean finish or an abort to the video stage.
module jtpopeye_obj_dma
  import jtpopeye_obj_dma_pkg::*;
#(
  parameter int LEN    = 1024,
  parameter int RD_LAT = 2,
  parameter int ACK_TO = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          VB,
  input  logic          enable,
  output logic          busrq_n,
  input  logic          busak_n,
  output logic          dma_cs,
  output logic [AW-1:0] AD_DMA,
  input  logic [DW-1:0] DD_DMA,
  output logic [AW-1:0] obj_addr,
  output logic [DW-1:0] obj_data,
  output logic          obj_we,
  output logic          dma_busy,
  output logic          dma_done,
  output logic          dma_abort
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(LEN - 1);
  localparam logic [7:0]    TO_LAST   = 8'(ACK_TO - 1);

  dma_state_t    state, state_nx;
  logic [7:0]    to_cnt;
  logic          vb_l, vb_rise;
  logic          issue, to_clr, to_inc, addr_clr, flush;
  logic          fin_done, fin_abort;
  logic          p_vld, pipe_empty;
  logic [AW-1:0] p_addr;

  assign vb_rise = VB & ~vb_l;

  // VB history, sampled at the DMA clock rate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vb_l <= 1'b0;
    else if (cen) vb_l <= VB;
  end

  // Next-state logic; losing the bus while reading is checked every clk
  always_comb begin
    state_nx  = state;
    issue     = 1'b0;
    to_clr    = 1'b0;
    to_inc    = 1'b0;
    addr_clr  = 1'b0;
    flush     = 1'b0;
    fin_done  = 1'b0;
    fin_abort = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cen && vb_rise && enable) begin
          state_nx = ST_REQ;
          to_clr   = 1'b1;
        end
      end
      ST_REQ: begin
        if (cen) begin
          if (!busak_n) begin
            state_nx = ST_XFER;
            addr_clr = 1'b1;
          end else if (to_cnt == TO_LAST) begin
            state_nx = ST_ABORT;
          end else begin
            to_inc = 1'b1;
          end
        end
      end
      ST_XFER: begin
        if (busak_n) begin
          state_nx = ST_ABORT;
        end else if (cen) begin
          issue = 1'b1;
          if (AD_DMA == LAST_ADDR) state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (busak_n)         state_nx = ST_ABORT;
        else if (pipe_empty) state_nx = ST_REL;
      end
      ST_REL: begin
        if (cen && busak_n) begin
          state_nx = ST_IDLE;
          fin_done = 1'b1;
        end
      end
      ST_ABORT: begin
        flush = 1'b1;
        if (cen && busak_n) begin
          state_nx  = ST_IDLE;
          fin_abort = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    // Drop in-flight reads on the same edge that enters ABORT
    if (state_nx == ST_ABORT) flush = 1'b1;
  end

  // State register plus the one-clk completion/abort pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dma_done  <= 1'b0;
      dma_abort <= 1'b0;
    end else begin
      state     <= state_nx;
      dma_done  <= fin_done;
      dma_abort <= fin_abort;
    end
  end

  // Bus acknowledge timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      to_cnt <= '0;
    else if (to_clr) to_cnt <= '0;
    else if (to_inc) to_cnt <= to_cnt + 8'd1;
  end

  // Read address counter: restarts on bus grant, parks on the last address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        AD_DMA <= '0;
    else if (addr_clr) AD_DMA <= '0;
    else if (issue)    AD_DMA <= addr_step(AD_DMA, LAST_ADDR);
  end

  jtpopeye_obj_dma_pipe #(
    .RD_LAT (RD_LAT)
  ) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_vld   (issue),
    .in_addr  (AD_DMA),
    .out_vld  (p_vld),
    .out_addr (p_addr),
    .empty    (pipe_empty)
  );

  assign busrq_n  = !((state == ST_REQ) || (state == ST_XFER) || (state == ST_DRAIN));
  assign dma_cs   = (state == ST_XFER) || (state == ST_DRAIN);
  assign dma_busy = (state != ST_IDLE);

  // Buffer write lines up with the RAM byte returning for the retiring tag
  assign obj_we   = p_vld;
  assign obj_addr = p_vld ? p_addr : '0;
  assign obj_data = p_vld ? DD_DMA : '0;

endmodule

// File: tb/tb_jtpopeye_obj_dma.sv
module tb_jtpopeye_obj_dma;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic cen = 1'b0;
  int   cen_div = 1;
  int   cen_cnt = 0;
  int   cyc = 0;

  // clock enable generator: one cen every cen_div clk
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cen_cnt >= cen_div - 1) begin
      cen_cnt <= 0;
      cen     <= 1'b1;
    end else begin
      cen_cnt <= cen_cnt + 1;
      cen     <= 1'b0;
    end
  end

  // ---------------- main DUT (LEN=1024) ----------------
  logic       VB = 1'b0, enable = 1'b1;
  logic       busrq_n, busak_n = 1'b1, dma_cs;
  logic [9:0] AD_DMA, obj_addr;
  logic [7:0] DD_DMA = 8'h00, obj_data, d1 = 8'h00;
  logic       obj_we, dma_busy, dma_done, dma_abort;
  bit         ack_block = 1'b0;
  int         ack_cnt = 0;

  jtpopeye_obj_dma #(.LEN(1024), .RD_LAT(2), .ACK_TO(255)) u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .VB(VB), .enable(enable),
    .busrq_n(busrq_n), .busak_n(busak_n), .dma_cs(dma_cs), .AD_DMA(AD_DMA),
    .DD_DMA(DD_DMA), .obj_addr(obj_addr), .obj_data(obj_data), .obj_we(obj_we),
    .dma_busy(dma_busy), .dma_done(dma_done), .dma_abort(dma_abort)
  );

  // Z80 bus model: ack 3 cen after request, release when request drops
  always @(posedge clk) if (cen) begin
    if (busrq_n || ack_block) begin
      ack_cnt <= 0;
      busak_n <= 1'b1;
    end else if (ack_cnt == 2) begin
      busak_n <= 1'b0;
    end else begin
      ack_cnt <= ack_cnt + 1;
    end
  end

  // main RAM model, two clk read latency
  always @(posedge clk) begin
    d1     <= dma_cs ? (AD_DMA[7:0] ^ 8'h5A) : 8'h00;
    DD_DMA <= d1;
  end

  // ---------------- second DUT (LEN=16) ----------------
  logic       VB16 = 1'b0, en16 = 1'b1;
  logic       busrq16_n, busak16_n = 1'b1, cs16;
  logic [9:0] ad16, oa16;
  logic [7:0] dd16 = 8'h00, od16, d16 = 8'h00;
  logic       we16, busy16, done16, abort16;
  int         ack16_cnt = 0;

  jtpopeye_obj_dma #(.LEN(16), .RD_LAT(2), .ACK_TO(255)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .cen(cen), .VB(VB16), .enable(en16),
    .busrq_n(busrq16_n), .busak_n(busak16_n), .dma_cs(cs16), .AD_DMA(ad16),
    .DD_DMA(dd16), .obj_addr(oa16), .obj_data(od16), .obj_we(we16),
    .dma_busy(busy16), .dma_done(done16), .dma_abort(abort16)
  );

  always @(posedge clk) if (cen) begin
    if (busrq16_n) begin
      ack16_cnt <= 0;
      busak16_n <= 1'b1;
    end else if (ack16_cnt == 2) begin
      busak16_n <= 1'b0;
    end else begin
      ack16_cnt <= ack16_cnt + 1;
    end
  end

  always @(posedge clk) begin
    d16  <= cs16 ? (ad16[7:0] ^ 8'h5A) : 8'h00;
    dd16 <= d16;
  end

  // ---------------- scoreboards ----------------
  int checks = 0, errors = 0;
  logic [17:0] exp_q[$];
  logic [17:0] exp16_q[$];
  logic [7:0]  seq16[$];
  int wr_cnt = 0, done_cnt = 0, abort_cnt = 0, rq_low_cnt = 0, last_addr = 0;
  int wr16_cnt = 0, done16_cnt = 0, issue_t = 0, we_t = 0;
  bit seen_issue = 1'b0, seen_we = 1'b0;

  always @(negedge clk) if (rst_n) begin
    logic [17:0] e;
    if (dma_done)  done_cnt++;
    if (dma_abort) abort_cnt++;
    if (!busrq_n)  rq_low_cnt++;
    if (obj_we) begin
      wr_cnt++;
      last_addr = obj_addr;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got addr=%0d data=%02h want no write", obj_addr, obj_data);
      end else begin
        e = exp_q.pop_front();
        if (obj_addr !== e[17:8] || obj_data !== e[7:0] || busrq_n !== 1'b0) begin
          errors++;
          $display("FAIL wr_data got addr=%0d data=%02h busrq_n=%b want addr=%0d data=%02h busrq_n=0",
                   obj_addr, obj_data, busrq_n, e[17:8], e[7:0]);
        end
      end
    end
  end

  always @(negedge clk) if (rst_n) begin
    logic [17:0] e;
    if (done16) done16_cnt++;
    if (cs16 && cen && !seen_issue) begin
      seen_issue = 1'b1;
      issue_t = cyc;
    end
    if (we16) begin
      if (!seen_we) begin
        seen_we = 1'b1;
        we_t = cyc;
      end
      wr16_cnt++;
      seq16.push_back(od16);
      checks++;
      if (exp16_q.size() == 0) begin
        errors++;
        $display("FAIL wr16_unexpected got addr=%0d data=%02h want no write", oa16, od16);
      end else begin
        e = exp16_q.pop_front();
        if (oa16 !== e[17:8] || od16 !== e[7:0]) begin
          errors++;
          $display("FAIL wr16_data got addr=%0d data=%02h want addr=%0d data=%02h",
                   oa16, od16, e[17:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got no end of run want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic push_exp(input bit which16, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      if (which16) exp16_q.push_back({10'(i), 8'(i) ^ 8'h5A});
      else         exp_q.push_back({10'(i), 8'(i) ^ 8'h5A});
    end
  endtask

  task automatic vb_pulse(input bit which16);
    @(negedge clk);
    if (which16) VB16 = 1'b1; else VB = 1'b1;
    repeat (2 * cen_div + 2) @(negedge clk);
    if (which16) VB16 = 1'b0; else VB = 1'b0;
    repeat (2 * cen_div + 2) @(negedge clk);
  endtask

  task automatic wait_idle(input bit which16, input int budget, input string name);
    int n = 0;
    while ((which16 ? busy16 : dma_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (which16 ? busy16 : dma_busy) begin
      errors++;
      $display("FAIL %s_idle got busy after %0d clk want idle", name, budget);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_wr(input int target, input int budget, input string name);
    int n = 0;
    while (wr_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wr_cnt < target) begin
      errors++;
      $display("FAIL %s_wr got %0d writes want %0d", name, wr_cnt, target);
    end
  endtask

  task automatic clear_counts();
    wr_cnt = 0; done_cnt = 0; abort_cnt = 0; rq_low_cnt = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busrq_n !== 1'b1) begin errors++; $display("FAIL rst_busrq_n got %b want 1", busrq_n); end
    checks++; if (dma_cs !== 1'b0) begin errors++; $display("FAIL rst_dma_cs got %b want 0", dma_cs); end
    checks++; if (AD_DMA !== 10'd0) begin errors++; $display("FAIL rst_ad_dma got %0d want 0", AD_DMA); end
    checks++; if (obj_we !== 1'b0 || obj_addr !== 10'd0 || obj_data !== 8'd0) begin
      errors++; $display("FAIL rst_obj got we=%b addr=%0d data=%02h want 0/0/00", obj_we, obj_addr, obj_data);
    end
    checks++; if (dma_busy !== 1'b0 || dma_done !== 1'b0 || dma_abort !== 1'b0) begin
      errors++; $display("FAIL rst_status got busy=%b done=%b abort=%b want 000", dma_busy, dma_done, dma_abort);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_normal();
    clear_counts();
    push_exp(1'b0, 0, 1023);
    vb_pulse(1'b0);
    wait_idle(1'b0, 5000, "normal");
    checks++; if (wr_cnt != 1024) begin errors++; $display("FAIL normal_count got %0d want 1024", wr_cnt); end
    checks++; if (done_cnt != 1 || abort_cnt != 0) begin
      errors++; $display("FAIL normal_pulses got done=%0d abort=%0d want 1/0", done_cnt, abort_cnt);
    end
    checks++; if (busrq_n !== 1'b1 || dma_cs !== 1'b0) begin
      errors++; $display("FAIL normal_bus got busrq_n=%b cs=%b want 1/0", busrq_n, dma_cs);
    end
    checks++; if (AD_DMA !== 10'd1023) begin errors++; $display("FAIL normal_ad_sat got %0d want 1023", AD_DMA); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL normal_left got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_timeout();
    clear_counts();
    ack_block = 1'b1;
    vb_pulse(1'b0);
    wait_idle(1'b0, 1000, "timeout");
    checks++; if (rq_low_cnt != 255) begin errors++; $display("FAIL timeout_ticks got %0d want 255", rq_low_cnt); end
    checks++; if (abort_cnt != 1 || done_cnt != 0) begin
      errors++; $display("FAIL timeout_pulses got abort=%0d done=%0d want 1/0", abort_cnt, done_cnt);
    end
    checks++; if (wr_cnt != 0) begin errors++; $display("FAIL timeout_writes got %0d want 0", wr_cnt); end
    checks++; if (busrq_n !== 1'b1 || dma_busy !== 1'b0) begin
      errors++; $display("FAIL timeout_bus got busrq_n=%b busy=%b want 1/0", busrq_n, dma_busy);
    end
    ack_block = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_retrigger();
    clear_counts();
    push_exp(1'b0, 0, 1023);
    vb_pulse(1'b0);
    wait_wr(500, 3000, "retrig500");
    vb_pulse(1'b0);
    wait_wr(700, 3000, "retrig700");
    enable = 1'b0;
    wait_wr(900, 3000, "retrig900");
    enable = 1'b1;
    wait_idle(1'b0, 5000, "retrig");
    repeat (20) @(negedge clk);
    checks++; if (wr_cnt != 1024) begin errors++; $display("FAIL retrig_count got %0d want 1024", wr_cnt); end
    checks++; if (done_cnt != 1 || abort_cnt != 0) begin
      errors++; $display("FAIL retrig_pulses got done=%0d abort=%0d want 1/0", done_cnt, abort_cnt);
    end
    checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL retrig_queued got busy=%b want 0", dma_busy); end
    exp_q.delete();
  endtask

  task automatic test_bus_loss();
    clear_counts();
    push_exp(1'b0, 0, 102);
    vb_pulse(1'b0);
    wait_wr(101, 3000, "busloss");
    ack_block = 1'b1;
    wait_idle(1'b0, 1000, "busloss");
    checks++; if (abort_cnt != 1 || done_cnt != 0) begin
      errors++; $display("FAIL busloss_pulses got abort=%0d done=%0d want 1/0", abort_cnt, done_cnt);
    end
    checks++; if (wr_cnt < 101 || wr_cnt > 103 || last_addr > 102) begin
      errors++; $display("FAIL busloss_tail got writes=%0d last=%0d want 101..103 last<=102", wr_cnt, last_addr);
    end
    exp_q.delete();
    ack_block = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    clear_counts();
    push_exp(1'b0, 0, 1023);
    vb_pulse(1'b0);
    wait_wr(301, 3000, "rstmid");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busrq_n !== 1'b1 || dma_cs !== 1'b0 || dma_busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_bus got busrq_n=%b cs=%b busy=%b want 1/0/0", busrq_n, dma_cs, dma_busy);
    end
    checks++; if (AD_DMA !== 10'd0 || obj_we !== 1'b0 || obj_addr !== 10'd0 || obj_data !== 8'd0) begin
      errors++; $display("FAIL rstmid_out got ad=%0d we=%b addr=%0d data=%02h want 0/0/0/00",
                         AD_DMA, obj_we, obj_addr, obj_data);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    clear_counts();
    push_exp(1'b0, 0, 1023);
    vb_pulse(1'b0);
    wait_idle(1'b0, 5000, "rstmid_again");
    checks++; if (wr_cnt != 1024 || done_cnt != 1) begin
      errors++; $display("FAIL rstmid_again got writes=%0d done=%0d want 1024/1", wr_cnt, done_cnt);
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rstmid_left got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic run16(input int div, input string name);
    @(negedge clk);
    cen_div = div;
    repeat (8) @(negedge clk);
    wr16_cnt = 0; done16_cnt = 0; seen_issue = 1'b0; seen_we = 1'b0;
    seq16.delete();
    push_exp(1'b1, 0, 15);
    vb_pulse(1'b1);
    wait_idle(1'b1, 2000, name);
    checks++; if (wr16_cnt != 16 || done16_cnt != 1) begin
      errors++; $display("FAIL %s_count got writes=%0d done=%0d want 16/1", name, wr16_cnt, done16_cnt);
    end
    checks++; if (!seen_we || !seen_issue || we_t - issue_t != 2) begin
      errors++; $display("FAIL %s_latency got %0d clk want 2", name, we_t - issue_t);
    end
    exp16_q.delete();
  endtask

  task automatic test_cen_rates();
    logic [7:0] seq_a[$];
    run16(1, "cen1");
    seq_a = seq16;
    run16(4, "cen4");
    checks++;
    if (seq_a.size() != 16 || seq16.size() != 16) begin
      errors++; $display("FAIL cen_seq_len got %0d/%0d want 16/16", seq_a.size(), seq16.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (seq_a[i] !== seq16[i]) begin
          errors++;
          $display("FAIL cen_seq got byte%0d=%02h want %02h", i, seq16[i], seq_a[i]);
          break;
        end
      end
    end
    @(negedge clk);
    cen_div = 1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_retrigger();
    test_bus_loss();
    test_reset_mid();
    test_cen_rates();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
